// File: rtl/ps2_key_typer.sv
// ASCII-to-PS/2 set-2 autotyper: turns accepted characters into toggle-strobed make/break
// events on an 11-bit ps2_key bus, pressing and releasing left shift around shifted keys.
module ps2_key_typer #(
  parameter logic [23:0] HOLD_CYCLES = 24'd100000,
  parameter logic [23:0] GAP_CYCLES  = 24'd100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        busy,
  output logic [10:0] ps2_key,
  output logic        unmapped
);

  typedef enum logic [2:0] {StIdle, StShDn, StKeyDn, StKeyUp, StGap, StErr} state_e;

  localparam logic [7:0]  ShiftCode = 8'h12;
  localparam logic [23:0] HoldLoad  = HOLD_CYCLES - 24'd1;
  localparam logic [23:0] GapLoad   = GAP_CYCLES - 24'd1;

  state_e      state_q;
  logic [23:0] cnt_q;
  logic [7:0]  code_q;
  logic        shift_q;

  logic [7:0]  up;
  logic        lk_ok;
  logic        lk_shift;
  logic [7:0]  lk_code;

  // Lower-case letters fold onto the upper-case entries.
  always_comb begin
    up = char_data;
    if (char_data >= 8'h61 && char_data <= 8'h7a) up = char_data - 8'h20;
    lk_ok    = 1'b1;
    lk_shift = 1'b0;
    lk_code  = 8'h00;
    case (up)
      8'h41: lk_code = 8'h1c;  8'h42: lk_code = 8'h32;  8'h43: lk_code = 8'h21;
      8'h44: lk_code = 8'h23;  8'h45: lk_code = 8'h24;  8'h46: lk_code = 8'h2b;
      8'h47: lk_code = 8'h34;  8'h48: lk_code = 8'h33;  8'h49: lk_code = 8'h43;
      8'h4a: lk_code = 8'h3b;  8'h4b: lk_code = 8'h42;  8'h4c: lk_code = 8'h4b;
      8'h4d: lk_code = 8'h3a;  8'h4e: lk_code = 8'h31;  8'h4f: lk_code = 8'h44;
      8'h50: lk_code = 8'h4d;  8'h51: lk_code = 8'h15;  8'h52: lk_code = 8'h2d;
      8'h53: lk_code = 8'h1b;  8'h54: lk_code = 8'h2c;  8'h55: lk_code = 8'h3c;
      8'h56: lk_code = 8'h2a;  8'h57: lk_code = 8'h1d;  8'h58: lk_code = 8'h22;
      8'h59: lk_code = 8'h35;  8'h5a: lk_code = 8'h1a;
      8'h30: lk_code = 8'h45;  8'h31: lk_code = 8'h16;  8'h32: lk_code = 8'h1e;
      8'h33: lk_code = 8'h26;  8'h34: lk_code = 8'h25;  8'h35: lk_code = 8'h2e;
      8'h36: lk_code = 8'h36;  8'h37: lk_code = 8'h3d;  8'h38: lk_code = 8'h3e;
      8'h39: lk_code = 8'h46;
      8'h20: lk_code = 8'h29;  8'h0d: lk_code = 8'h5a;  8'h08: lk_code = 8'h66;
      8'h1b: lk_code = 8'h76;  8'h2c: lk_code = 8'h41;  8'h2e: lk_code = 8'h49;
      8'h2f: lk_code = 8'h4a;  8'h3b: lk_code = 8'h4c;  8'h2d: lk_code = 8'h4e;
      8'h3d: lk_code = 8'h55;  8'h27: lk_code = 8'h52;
      8'h21: begin lk_code = 8'h16; lk_shift = 1'b1; end
      8'h40: begin lk_code = 8'h1e; lk_shift = 1'b1; end
      8'h23: begin lk_code = 8'h26; lk_shift = 1'b1; end
      8'h24: begin lk_code = 8'h25; lk_shift = 1'b1; end
      8'h25: begin lk_code = 8'h2e; lk_shift = 1'b1; end
      8'h26: begin lk_code = 8'h3d; lk_shift = 1'b1; end
      8'h2a: begin lk_code = 8'h3e; lk_shift = 1'b1; end
      8'h28: begin lk_code = 8'h46; lk_shift = 1'b1; end
      8'h29: begin lk_code = 8'h45; lk_shift = 1'b1; end
      8'h2b: begin lk_code = 8'h55; lk_shift = 1'b1; end
      8'h3a: begin lk_code = 8'h4c; lk_shift = 1'b1; end
      8'h3c: begin lk_code = 8'h41; lk_shift = 1'b1; end
      8'h3e: begin lk_code = 8'h49; lk_shift = 1'b1; end
      8'h3f: begin lk_code = 8'h4a; lk_shift = 1'b1; end
      8'h22: begin lk_code = 8'h52; lk_shift = 1'b1; end
      default: lk_ok = 1'b0;
    endcase
  end

  // The final release goes straight into StGap so ready returns GAP_CYCLES after it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= 24'd0;
      code_q     <= 8'h00;
      shift_q    <= 1'b0;
      char_ready <= 1'b0;
      busy       <= 1'b0;
      ps2_key    <= 11'h000;
      unmapped   <= 1'b0;
    end else begin
      unmapped <= 1'b0;
      case (state_q)
        StIdle: begin
          char_ready <= 1'b1;
          busy       <= 1'b0;
          if (char_valid && char_ready) begin
            char_ready <= 1'b0;
            busy       <= 1'b1;
            if (!lk_ok) begin
              state_q  <= StErr;
              unmapped <= 1'b1;
            end else begin
              code_q  <= lk_code;
              shift_q <= lk_shift;
              cnt_q   <= HoldLoad;
              ps2_key <= {~ps2_key[10], 2'b10, lk_shift ? ShiftCode : lk_code};
              state_q <= lk_shift ? StShDn : StKeyDn;
            end
          end
        end
        StShDn: begin
          if (cnt_q == 24'd0) begin
            ps2_key <= {~ps2_key[10], 2'b10, code_q};
            cnt_q   <= HoldLoad;
            state_q <= StKeyDn;
          end else cnt_q <= cnt_q - 24'd1;
        end
        StKeyDn: begin
          if (cnt_q == 24'd0) begin
            ps2_key <= {~ps2_key[10], 2'b00, code_q};
            cnt_q   <= shift_q ? HoldLoad : GapLoad;
            state_q <= shift_q ? StKeyUp : StGap;
          end else cnt_q <= cnt_q - 24'd1;
        end
        StKeyUp: begin
          if (cnt_q == 24'd0) begin
            ps2_key <= {~ps2_key[10], 2'b00, ShiftCode};
            cnt_q   <= GapLoad;
            state_q <= StGap;
          end else cnt_q <= cnt_q - 24'd1;
        end
        StGap: begin
          if (cnt_q == 24'd0) begin
            state_q    <= StIdle;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end else cnt_q <= cnt_q - 24'd1;
        end
        default: begin
          state_q    <= StIdle;
          char_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_typer.sv
// Scoreboard bench for ps2_key_typer: stimulus queues expected events/ready/unmapped times,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_ps2_key_typer;

  localparam int H = 4;
  localparam int G = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        busy;
  logic [10:0] ps2_key;
  logic        unmapped;

  ps2_key_typer #(
    .HOLD_CYCLES(24'(H)),
    .GAP_CYCLES (24'(G))
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .busy      (busy),
    .ps2_key   (ps2_key),
    .unmapped  (unmapped)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] key;
    int         t;
  } ev_t;

  ev_t ev_q[$];
  int  rdy_q[$];
  int  um_q[$];
  int  checks = 0;
  int  errors = 0;
  int  um_seen = 0;

  logic       m_ok[256];
  logic [7:0] m_code[256];
  logic       m_sh[256];
  int         m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void build_model();
    logic [7:0]  lc[26] = '{8'h1c, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2b, 8'h34, 8'h33, 8'h43,
                            8'h3b, 8'h42, 8'h4b, 8'h3a, 8'h31, 8'h44, 8'h4d, 8'h15, 8'h2d,
                            8'h1b, 8'h2c, 8'h3c, 8'h2a, 8'h1d, 8'h22, 8'h35, 8'h1a};
    logic [15:0] un[21] = '{16'h3045, 16'h3116, 16'h321e, 16'h3326, 16'h3425, 16'h352e,
                            16'h3636, 16'h373d, 16'h383e, 16'h3946, 16'h2029, 16'h0d5a,
                            16'h0866, 16'h1b76, 16'h2c41, 16'h2e49, 16'h2f4a, 16'h3b4c,
                            16'h2d4e, 16'h3d55, 16'h2752};
    logic [15:0] sh[15] = '{16'h2116, 16'h401e, 16'h2326, 16'h2425, 16'h252e, 16'h263d,
                            16'h2a3e, 16'h2846, 16'h2945, 16'h2b55, 16'h3a4c, 16'h3c41,
                            16'h3e49, 16'h3f4a, 16'h2252};
    for (int i = 0; i < 256; i++) begin
      m_ok[i] = 1'b0; m_code[i] = 8'h00; m_sh[i] = 1'b0;
    end
    for (int i = 0; i < 26; i++) begin
      m_ok[8'h41 + i] = 1'b1; m_code[8'h41 + i] = lc[i];
      m_ok[8'h61 + i] = 1'b1; m_code[8'h61 + i] = lc[i];
    end
    for (int i = 0; i < 21; i++) begin
      m_ok[un[i][15:8]] = 1'b1; m_code[un[i][15:8]] = un[i][7:0];
    end
    for (int i = 0; i < 15; i++) begin
      m_ok[sh[i][15:8]] = 1'b1; m_code[sh[i][15:8]] = sh[i][7:0]; m_sh[sh[i][15:8]] = 1'b1;
    end
    m_count = 0;
    for (int i = 0; i < 256; i++) if (m_ok[i]) m_count++;
  endfunction

  function automatic void push_ev(input logic press, input logic [7:0] code, input int t);
    ev_t e;
    e.key = {press, 1'b0, code};
    e.t   = t;
    ev_q.push_back(e);
  endfunction

  // Monitor: compares every DUT-presented event, ready rise and unmapped pulse in order.
  logic prev_tog = 1'b0;
  logic prev_rdy = 1'b0;
  ev_t  mon_e;
  int   mon_t;
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (ps2_key[10] !== prev_tog) begin
        if (ev_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected event: got %0h required none (cycle %0d)", ps2_key, cyc);
        end else begin
          mon_e = ev_q.pop_front();
          check("event key", 32'(ps2_key[9:0]), 32'(mon_e.key));
          check("event time", cyc, mon_e.t);
        end
      end
      if (char_ready === 1'b1 && prev_rdy === 1'b0) begin
        if (rdy_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected ready: got 1 required 0 (cycle %0d)", cyc);
        end else begin
          mon_t = rdy_q.pop_front();
          check("ready time", cyc, mon_t);
        end
      end
      if (unmapped === 1'b1) begin
        um_seen++;
        if (um_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected unmapped: got 1 required 0 (cycle %0d)", cyc);
        end else begin
          mon_t = um_q.pop_front();
          check("unmapped time", cyc, mon_t);
        end
      end
    end
    prev_tog = ps2_key[10];
    prev_rdy = char_ready;
  end

  // Called on a negedge; returns on the negedge after acceptance.
  task automatic send(input logic [7:0] c, input bit hold, output int acc);
    int n = 0;
    char_data  = c;
    char_valid = 1'b1;
    while (char_ready !== 1'b1 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept timeout: got no ready required ready for %0h", c);
      char_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (!m_ok[c]) begin
      um_q.push_back(acc + 1);
      rdy_q.push_back(acc + 2);
    end else if (m_sh[c]) begin
      push_ev(1'b1, 8'h12, acc + 1);
      push_ev(1'b1, m_code[c], acc + 1 + H);
      push_ev(1'b0, m_code[c], acc + 1 + 2 * H);
      push_ev(1'b0, 8'h12, acc + 1 + 3 * H);
      rdy_q.push_back(acc + 1 + 3 * H + G);
    end else begin
      push_ev(1'b1, m_code[c], acc + 1);
      push_ev(1'b0, m_code[c], acc + 1 + H);
      rdy_q.push_back(acc + 1 + H + G);
    end
    @(negedge clk_sys);
    check("busy after accept", 32'(busy), 32'd1);
    check("ready after accept", 32'(char_ready), 32'd0);
    if (!hold) char_valid = 1'b0;
  endtask

  int a, a1, a2, um0, n;

  initial begin
    build_model();
    repeat (2) @(negedge clk_sys);
    check("reset ps2_key", 32'(ps2_key), 32'h000);
    check("reset ready", 32'(char_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset unmapped", 32'(unmapped), 32'd0);
    #2 reset_n = 1'b1;
    rdy_q.push_back(cyc + 1);
    @(negedge clk_sys);

    send(8'h41, 1'b0, a);
    send(8'h22, 1'b0, a);
    send(8'h80, 1'b1, a1);
    send(8'h35, 1'b0, a2);
    check("back-to-back accept gap", a2 - a1, 2);

    // Data changes while busy must not be picked up.
    send(8'h62, 1'b1, a);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      char_data = 8'h5a - 8'(i * 9);
    end
    @(negedge clk_sys);
    char_valid = 1'b0;

    // Reset between the shift press and key press.
    send(8'h3f, 1'b0, a);
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("mid reset ps2_key", 32'(ps2_key), 32'h000);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset ready", 32'(char_ready), 32'd0);
    ev_q.delete();
    rdy_q.delete();
    um_q.delete();
    @(negedge clk_sys);
    #2 reset_n = 1'b1;
    rdy_q.push_back(cyc + 1);
    @(negedge clk_sys);
    send(8'h6b, 1'b0, a);

    um0 = um_seen;
    for (int i = 0; i < 256; i++) send(8'(i), 1'b0, a);

    n = 0;
    while ((ev_q.size() + rdy_q.size() + um_q.size()) != 0 && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    @(negedge clk_sys);
    check("leftover expectations", ev_q.size() + rdy_q.size() + um_q.size(), 0);
    check("sweep unmapped count", um_seen - um0, 256 - m_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
